// File: rtl/reg_file_sb.sv
// Register file with per-register pending-write scoreboard (2-bit counters).
// Define RF_BYPASS_EN to forward same-cycle writeback data and post-update busy to the read ports.
module reg_file_sb #(
    parameter int DATA = 32,
    parameter int NREG = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [4:0]      rs_addr,
    input  logic [4:0]      rt_addr,
    output logic [DATA-1:0] rs_data,
    output logic [DATA-1:0] rt_data,
    input  logic            wr_en,
    input  logic [4:0]      wr_addr,
    input  logic [DATA-1:0] wr_data,
    input  logic            issue_en,
    input  logic [4:0]      issue_dest,
    output logic            rs_busy,
    output logic            rt_busy,
    output logic            drained,
    output logic            sb_overflow
);

    logic [DATA-1:0] regs    [NREG];
    logic [1:0]      cnt_q   [NREG];
    logic [1:0]      cnt_nxt [NREG];
    logic            ovf_hit;
    logic            ovf_q;

    function automatic logic hits(input logic en, input logic [4:0] a, input int idx);
        return en && (idx != 0) && (a == 5'(idx));
    endfunction

    // Saturating pending counters; a same-cycle issue and write to one register cancel out.
    always_comb begin
        ovf_hit = 1'b0;
        for (int i = 0; i < NREG; i++) begin
            cnt_nxt[i] = cnt_q[i];
            if (hits(issue_en, issue_dest, i) && !hits(wr_en, wr_addr, i)) begin
                if (cnt_q[i] == 2'd3)
                    ovf_hit = 1'b1;
                else
                    cnt_nxt[i] = cnt_q[i] + 2'd1;
            end else if (hits(wr_en, wr_addr, i) && !hits(issue_en, issue_dest, i)) begin
                if (cnt_q[i] != 2'd0)
                    cnt_nxt[i] = cnt_q[i] - 2'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i]  <= '0;
                cnt_q[i] <= 2'd0;
            end
            ovf_q <= 1'b0;
        end else begin
            if (wr_en && wr_addr != 5'd0)
                regs[wr_addr] <= wr_data;
            for (int i = 0; i < NREG; i++)
                cnt_q[i] <= cnt_nxt[i];
            if (ovf_hit)
                ovf_q <= 1'b1;
        end
    end

    // Bypass is suppressed under reset so outputs read as cleared while rst is high.
    always_comb begin
        rs_data = '0;
        rs_busy = 1'b0;
        if (rs_addr != 5'd0) begin
            rs_data = regs[rs_addr];
            rs_busy = (cnt_q[rs_addr] != 2'd0);
`ifdef RF_BYPASS_EN
            if (!rst && wr_en && wr_addr == rs_addr) begin
                rs_data = wr_data;
                rs_busy = (cnt_nxt[rs_addr] != 2'd0);
            end
`endif
        end
    end

    always_comb begin
        rt_data = '0;
        rt_busy = 1'b0;
        if (rt_addr != 5'd0) begin
            rt_data = regs[rt_addr];
            rt_busy = (cnt_q[rt_addr] != 2'd0);
`ifdef RF_BYPASS_EN
            if (!rst && wr_en && wr_addr == rt_addr) begin
                rt_data = wr_data;
                rt_busy = (cnt_nxt[rt_addr] != 2'd0);
            end
`endif
        end
    end

    always_comb begin
        drained = 1'b1;
        for (int i = 0; i < NREG; i++)
            if (cnt_q[i] != 2'd0)
                drained = 1'b0;
    end

    assign sb_overflow = ovf_q;

endmodule

// File: tb/tb_reg_file_sb.sv
// Self-checking bench for reg_file_sb: directed scenarios plus randomized traffic against an array model.
module tb_reg_file_sb;
    localparam int DATA = 32;
    localparam int NREG = 32;
    localparam int VW   = 2 * DATA + 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [4:0]      rs_addr, rt_addr, wr_addr, issue_dest;
    logic [DATA-1:0] rs_data, rt_data, wr_data;
    logic            wr_en, issue_en;
    logic            rs_busy, rt_busy, drained, sb_overflow;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DATA-1:0] m_reg [NREG];
    int              m_cnt [NREG];
    bit              m_ovf;

    logic [VW-1:0] act, exp_v;

    reg_file_sb #(.DATA(DATA), .NREG(NREG)) dut (
        .clk(clk), .rst(rst),
        .rs_addr(rs_addr), .rt_addr(rt_addr),
        .rs_data(rs_data), .rt_data(rt_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .issue_en(issue_en), .issue_dest(issue_dest),
        .rs_busy(rs_busy), .rt_busy(rt_busy),
        .drained(drained), .sb_overflow(sb_overflow)
    );

    always #5 clk = ~clk;

    assign act = {rs_data, rt_data, rs_busy, rt_busy, drained, sb_overflow};

    function automatic void model_reset();
        for (int i = 0; i < NREG; i++) begin
            m_reg[i] = '0;
            m_cnt[i] = 0;
        end
        m_ovf = 1'b0;
    endfunction

    // Pending count of register a after the coming edge, from the current inputs.
    function automatic int next_cnt(input int a);
        int  c   = m_cnt[a];
        bit  inc = issue_en && issue_dest == 5'(a) && a != 0;
        bit  dec = wr_en && wr_addr == 5'(a) && a != 0;
        if (inc && !dec && c < 3) c++;
        if (dec && !inc && c > 0) c--;
        return c;
    endfunction

    function automatic logic [DATA-1:0] exp_data(input logic [4:0] a);
        if (a == 0) return '0;
`ifdef RF_BYPASS_EN
        if (wr_en && wr_addr == a) return wr_data;
`endif
        return m_reg[a];
    endfunction

    function automatic logic exp_busy(input logic [4:0] a);
        if (a == 0) return 1'b0;
`ifdef RF_BYPASS_EN
        if (wr_en && wr_addr == a) return next_cnt(int'(a)) != 0;
`endif
        return m_cnt[a] != 0;
    endfunction

    function automatic logic exp_drained();
        for (int i = 0; i < NREG; i++)
            if (m_cnt[i] != 0) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [VW-1:0] model_view();
        return {exp_data(rs_addr), exp_data(rt_addr), exp_busy(rs_addr), exp_busy(rt_addr),
                exp_drained(), m_ovf};
    endfunction

    task automatic drive(input bit ie, input logic [4:0] id, input bit we,
                         input logic [4:0] wa, input logic [DATA-1:0] wd);
        issue_en = ie; issue_dest = id; wr_en = we; wr_addr = wa; wr_data = wd;
    endtask

    task automatic tick();
        int nc [NREG];
        if (issue_en && issue_dest != 0 && !(wr_en && wr_addr == issue_dest) && m_cnt[issue_dest] == 3)
            m_ovf = 1'b1;
        for (int i = 0; i < NREG; i++) nc[i] = next_cnt(i);
        for (int i = 0; i < NREG; i++) m_cnt[i] = nc[i];
        if (wr_en && wr_addr != 0) m_reg[wr_addr] = wr_data;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        drive(0, 0, 0, 0, '0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        apply_reset();
        for (int i = 0; i < NREG; i++) begin
            rs_addr = 5'(i);
            rt_addr = 5'(NREG - 1 - i);
            #1;
            n_checks++;
            if (act !== {{(2*DATA){1'b0}}, 4'b0010}) begin
                n_fail++;
                $display("FAIL reset_read addr=%0d got=%h want=%h", i, act, {{(2*DATA){1'b0}}, 4'b0010});
            end
        end
    endtask

    task automatic test_write_read();
        apply_reset();
        rs_addr = 5; rt_addr = 0;
        drive(0, 0, 1, 5, 32'hDEADBEEF);
        tick();
        drive(0, 0, 0, 0, '0);
        #1;
        n_checks++;
        if (rs_data !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL write_r5 got=%h want=%h", rs_data, 32'hDEADBEEF);
        end
        drive(0, 0, 1, 0, 32'h1234);
        tick();
        drive(0, 0, 0, 0, '0);
        rs_addr = 0;
        #1;
        n_checks++;
        if (rs_data !== 32'h0 || rs_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL write_r0 got data=%h busy=%b want data=0 busy=0", rs_data, rs_busy);
        end
    endtask

    task automatic test_saturate();
        apply_reset();
        rt_addr = 7; rs_addr = 0;
        for (int k = 0; k < 4; k++) begin
            drive(1, 7, 0, 0, '0);
            tick();
        end
        drive(0, 0, 0, 0, '0);
        #1;
        n_checks++;
        if ({rt_busy, drained, sb_overflow} !== 3'b101) begin
            n_fail++;
            $display("FAIL saturate got busy/drained/ovf=%b want=101", {rt_busy, drained, sb_overflow});
        end
        for (int k = 0; k < 3; k++) begin
            drive(0, 0, 1, 7, 32'(k + 100));
            tick();
            drive(0, 0, 0, 0, '0);
            #1;
            n_checks++;
            if ({rt_busy, drained, sb_overflow} !== ((k < 2) ? 3'b101 : 3'b011)) begin
                n_fail++;
                $display("FAIL drain_r7 step=%0d got=%b want=%b", k, {rt_busy, drained, sb_overflow},
                         ((k < 2) ? 3'b101 : 3'b011));
            end
        end
    endtask

    task automatic test_same_cycle();
        apply_reset();
        rs_addr = 9; rt_addr = 0;
        drive(1, 9, 0, 0, '0);
        tick();
        drive(1, 9, 1, 9, 32'h5555_1234);
        tick();
        drive(0, 0, 0, 0, '0);
        #1;
        n_checks++;
        if (rs_busy !== 1'b1 || rs_data !== 32'h5555_1234) begin
            n_fail++;
            $display("FAIL same_cycle got busy=%b data=%h want busy=1 data=55551234", rs_busy, rs_data);
        end
        drive(0, 0, 1, 9, 32'h0BAD_F00D);
        tick();
        drive(0, 0, 0, 0, '0);
        #1;
        n_checks++;
        if (rs_busy !== 1'b0 || drained !== 1'b1) begin
            n_fail++;
            $display("FAIL same_cycle_drain got busy=%b drained=%b want busy=0 drained=1", rs_busy, drained);
        end
    endtask

    task automatic test_bypass();
        logic [DATA-1:0] want_d;
        logic            want_b;
        apply_reset();
        rs_addr = 3; rt_addr = 0;
        drive(0, 0, 1, 3, 32'h1111_1111);
        tick();
        drive(1, 3, 0, 0, '0);
        tick();
        drive(0, 0, 1, 3, 32'hA5A5_A5A5);
        #1;
`ifdef RF_BYPASS_EN
        want_d = 32'hA5A5_A5A5; want_b = 1'b0;
`else
        want_d = 32'h1111_1111; want_b = 1'b1;
`endif
        n_checks++;
        if (rs_data !== want_d || rs_busy !== want_b) begin
            n_fail++;
            $display("FAIL bypass got data=%h busy=%b want data=%h busy=%b", rs_data, rs_busy, want_d, want_b);
        end
        tick();
        drive(0, 0, 0, 0, '0);
        #1;
        n_checks++;
        if (rs_data !== 32'hA5A5_A5A5 || rs_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL bypass_after got data=%h busy=%b want data=a5a5a5a5 busy=0", rs_data, rs_busy);
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        drive(0, 0, 1, 4, 32'h0000_CAFE);
        tick();
        drive(1, 4, 0, 0, '0);
        tick();
        drive(1, 6, 0, 0, '0);
        tick();
        drive(0, 0, 0, 0, '0);
        rs_addr = 4; rt_addr = 6;
        #1;
        n_checks++;
        if ({rs_data, rs_busy, rt_busy, drained} !== {32'h0000_CAFE, 3'b110}) begin
            n_fail++;
            $display("FAIL pre_reset got=%h want=%h", {rs_data, rs_busy, rt_busy, drained}, {32'h0000_CAFE, 3'b110});
        end
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (act !== {{(2*DATA){1'b0}}, 4'b0010}) begin
            n_fail++;
            $display("FAIL async_reset got=%h want=%h", act, {{(2*DATA){1'b0}}, 4'b0010});
        end
        drive(1, 4, 1, 6, 32'h7777_7777);
        @(posedge clk);
        #1;
        n_checks++;
        if (act !== {{(2*DATA){1'b0}}, 4'b0010}) begin
            n_fail++;
            $display("FAIL reset_ignores_inputs got=%h want=%h", act, {{(2*DATA){1'b0}}, 4'b0010});
        end
        drive(0, 0, 0, 0, '0);
        rst = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (act !== {{(2*DATA){1'b0}}, 4'b0010}) begin
            n_fail++;
            $display("FAIL after_reset got=%h want=%h", act, {{(2*DATA){1'b0}}, 4'b0010});
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int n = 0; n < 600; n++) begin
            drive(($urandom_range(0, 99) < 45), 5'($urandom_range(0, 7)),
                  ($urandom_range(0, 99) < 55), 5'($urandom_range(0, 7)), $urandom);
            rs_addr = 5'($urandom_range(0, 7));
            rt_addr = 5'($urandom_range(0, 7));
            #1;
            exp_v = model_view();
            n_checks++;
            if (act !== exp_v) begin
                n_fail++;
                $display("FAIL random cycle=%0d rs=%0d rt=%0d got=%h want=%h", n, rs_addr, rt_addr, act, exp_v);
            end
            tick();
        end
    endtask

    initial begin
        rst = 1'b1;
        rs_addr = 0; rt_addr = 0;
        drive(0, 0, 0, 0, '0);
        model_reset();
        test_reset();
        test_write_read();
        test_saturate();
        test_same_cycle();
        test_bypass();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/reg_file_sb.md
REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 Parameter: DATA, default 32, width of every register and data port.
REQ-002 Parameter: NREG, default 32, register count; address width is 5 bits.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 rs_addr, rt_addr  input  5 each  read-port addresses from decode.
REQ-006 rs_data, rt_data  output  DATA each  read-port data.
REQ-007 wr_en  input  1  writeback write strobe.
REQ-008 wr_addr  input  5  writeback destination.
REQ-009 wr_data  input  DATA  value from the writeback mux.
REQ-010 issue_en  input  1  decode issuing an instruction that will write issue_dest.
REQ-011 issue_dest  input  5  destination of the issuing instruction.
REQ-012 rs_busy, rt_busy  output  1 each  read register has an outstanding write.
REQ-013 drained  output  1  no outstanding writes on any register.
REQ-014 sb_overflow  output  1  sticky; issue attempted on a saturated pending count.

Function
REQ-015 Read ports SHALL be combinational, zero latency; address 0 SHALL always read 0.
REQ-016 When wr_en=1 and wr_addr!=0, register wr_addr SHALL take wr_data at the rising edge; writes to address 0 SHALL be discarded.
REQ-017 Each register 1..31 SHALL hold a 2-bit pending counter (0..3) covering up to three in-flight writers in the pipe.
REQ-018 Counter update per edge: +1 on issue_en to that register only, -1 on wr_en to that register only, unchanged when both target it in the same cycle.
REQ-019 Issue to a register whose counter is 3 (with no same-cycle write to it) SHALL leave the counter at 3 and set sb_overflow.
REQ-020 wr_en to a register whose counter is 0 SHALL write data and leave the counter at 0 (no underflow).
REQ-021 issue_en or wr_en with address 0 SHALL never change any counter; register 0 is never busy.
REQ-022 rs_busy/rt_busy SHALL be combinational: counter of the addressed register != 0.
REQ-023 drained SHALL be high, combinationally, exactly when all counters are 0; used to gate halt completion.
REQ-024 sb_overflow SHALL remain set until reset.

Reset
REQ-025 rst=1 SHALL immediately clear all registers, all counters, and sb_overflow, regardless of clk.
REQ-026 During and after reset: rs_data=rt_data=0, rs_busy=rt_busy=0, drained=1, sb_overflow=0.
REQ-027 Reset asserted mid-operation SHALL discard all pending writes and counts; an issue_en or wr_en in a cycle where rst is high SHALL have no effect.

Configuration
REQ-028 Macro RF_BYPASS_EN defined: a read whose address equals wr_addr with wr_en=1 and wr_addr!=0 SHALL return wr_data and report busy from the post-update counter value.
REQ-029 RF_BYPASS_EN undefined: that read SHALL return the stored (pre-write) value and busy from the current counter; the new value is visible the cycle after the edge.

Verification
REQ-030 Reset then read all 32 addresses -> all data 0, busy 0, drained 1, sb_overflow 0.
REQ-031 Write 0xDEADBEEF to r5, next cycle read rs_addr=5 -> 0xDEADBEEF; write 0x1234 to r0, read r0 -> 0.
REQ-032 Issue r7 three cycles, then fourth issue -> counter 3, rt_busy=1 for rt_addr=7, sb_overflow=1; three writes to r7 -> busy 0, drained 1.
REQ-033 Counter of r9 at 1, same-cycle issue_en and wr_en to r9 -> counter stays 1, rs_busy=1, r9 holds wr_data.
REQ-034 Same-cycle wr_en r3=0xA5A5A5A5 and rs_addr=3 with counter 1 -> with RF_BYPASS_EN: 0xA5A5A5A5, rs_busy=0; without: old value, rs_busy=1.
REQ-035 Issue r4 and r6, assert rst mid-cycle asynchronously -> outputs reset immediately, drained=1, r4/r6 read 0.
